// File: rtl/fmap_mem_arbiter.sv
// Round-robin arbiter sharing the feature-map BRAM port among fill engines.
// Bounded bursts per grant; read data returned with a one-hot requester tag.
module fmap_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arb_enable,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int TAG_D = MEM_LAT + 1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e                          state_q, state_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                owner_q, owner_d;
  logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]              gnt_q, gnt_d;
  logic                            mem_en_q, mem_en_d;
  logic                            mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]               mem_wdata_q, mem_wdata_d;
  logic [TAG_D-1:0][NUM_REQ-1:0]   tag_q, tag_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] tag_in;
  logic [CNT_W-1:0]   cnt_inc;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W:0]     win;
  logic               acc;
  logic               last;
  logic               rel;

  // Returns {found, index} of the first set bit searching up from p, wrapping.
  function automatic logic [PTR_W:0] pick(
    input logic [NUM_REQ-1:0] m,
    input logic [PTR_W-1:0]   p
  );
    logic [PTR_W:0] r;
    int             k;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NUM_REQ;
      if (m[k]) r = {1'b1, PTR_W'(k)};
    end
    return r;
  endfunction

  always_comb begin
    owner_oh = NUM_REQ'(1) << owner_q;
    acc      = (state_q == OWN) && req[owner_q];
    cnt_inc  = beat_cnt_q + CNT_W'(1);
    last     = acc && (cnt_inc == CNT_W'(MAX_BURST));
    rel      = (state_q == OWN) && (!req[owner_q] || last);
    next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    win      = '0;

    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    mem_en_d    = acc;
    mem_we_d    = acc && we[owner_q];
    mem_addr_d  = acc ? addr[owner_q*ADDR_W +: ADDR_W] : mem_addr_q;
    mem_wdata_d = acc ? wdata[owner_q*DATA_W +: DATA_W] : mem_wdata_q;
    tag_in      = (acc && !we[owner_q]) ? owner_oh : '0;

    if (state_q == IDLE) begin
      win = pick(req, rr_ptr_q);
      if (arb_enable && win[PTR_W]) begin
        state_d    = OWN;
        owner_d    = win[PTR_W-1:0];
        beat_cnt_d = '0;
      end
    end else begin
      if (acc) beat_cnt_d = cnt_inc;
      if (rel) begin
        rr_ptr_d = next_ptr;
        // A capped owner sits out this round so it re-competes last.
        win = pick(req & ~owner_oh, next_ptr);
        beat_cnt_d = '0;
        if (arb_enable && win[PTR_W]) begin
          owner_d = win[PTR_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
    end

    gnt_d = (state_d == OWN) ? (NUM_REQ'(1) << owner_d) : '0;

    tag_d    = '0;
    tag_d[0] = tag_in;
    for (int i = 1; i < TAG_D; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      gnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
    end
  end

  assign gnt       = gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = tag_q[MEM_LAT];
  assign rdata     = (|tag_q[MEM_LAT]) ? mem_rdata : '0;
  assign busy      = (state_q == OWN) || (|tag_q);

endmodule

// File: tb/tb_fmap_mem_arbiter.sv
// Bench for fmap_mem_arbiter: BRAM model plus a read-return scoreboard.
// Each scenario task drives stimulus and checks its own expectations.
module tb_fmap_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        arb_enable;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [55:0] addr;
  logic [63:0] wdata;
  logic [3:0]  gnt;
  logic [15:0] rdata;
  logic [3:0]  rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          cyc;
  } sb_t;

  sb_t sb[$];

  logic [15:0] bram [0:16383];
  bit          bw   [0:16383];

  fmap_mem_arbiter dut (
    .clk        (clk),
    .reset      (rst_n),
    .arb_enable (arb_enable),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [13:0] a);
    return {2'b00, a} ^ 16'hC3A5;
  endfunction

  // Single-port BRAM, one-cycle read latency; unwritten words hold init_val.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_wdata;
        bw[mem_addr]   <= 1'b1;
      end else begin
        mem_rdata <= bw[mem_addr] ? bram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  task automatic set_addr(input int i, input logic [13:0] a);
    addr[i*14 +: 14] = a;
  endtask

  task automatic set_wdata(input int i, input logic [15:0] d);
    wdata[i*16 +: 16] = d;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rvalid !== 4'b0000) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rvalid got rvalid=%b rdata=%h want none",
                   rvalid, rdata);
        end else begin
          e = sb.pop_front();
          if (rvalid !== (4'b0001 << e.id) || rdata !== e.data ||
              cyc != e.cyc) begin
            failures++;
            $display("FAIL read_return got rvalid=%b rdata=%h cyc=%0d want rvalid=%b rdata=%h cyc=%0d",
                     rvalid, rdata, cyc, 4'b0001 << e.id, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    req = '0;
    we = '0;
    arb_enable = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h en=%b we=%b addr=%h wd=%h busy=%b want all 0",
               gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy);
    end
    rst_n = 1'b1;
    arb_enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
  endtask

  task automatic test_single_read();
    req[1] = 1'b1;
    we[1] = 1'b0;
    set_addr(1, 14'h0010);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL single_gnt got %b want 0010", gnt);
    end
    for (int b = 0; b < 3; b++) begin
      sb.push_back('{1, init_val(14'h0010 + 14'(b)), cyc + 2});
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 ||
          mem_addr !== 14'h0010 + 14'(b)) begin
        failures++;
        $display("FAIL single_mem_addr beat %0d got en=%b we=%b addr=%h want 1 0 %h",
                 b, mem_en, mem_we, mem_addr, 14'h0010 + 14'(b));
      end
      if (b < 2) set_addr(1, 14'h0011 + 14'(b));
      else req[1] = 1'b0;
    end
    wait_drain();
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_addr(i, 14'h2000 + 14'(i));
      set_wdata(i, 16'h5000 + 16'(i));
    end
    we = 4'b1111;
    req = 4'b1111;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      exp = 4'b0001 << ((n / 16) % 4);
      checks++;
      if (gnt !== exp || mem_en !== (n > 0)) begin
        failures++;
        $display("FAIL fairness cycle %0d got gnt=%b en=%b want %b %b",
                 n, gnt, mem_en, exp, n > 0);
      end
    end
    req = '0;
    we = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst_cap();
    int beats;
    int n;
    logic exp;
    we[2] = 1'b0;
    set_addr(2, 14'h0400);
    req[2] = 1'b1;
    beats = 0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      set_addr(2, 14'h0400 + 14'(beats));
      if (beats == 40) break;
      exp = (n % 17) != 16;
      checks++;
      if (gnt !== (exp ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL burst_cap cycle %0d got gnt=%b want %b",
                 n, gnt, exp ? 4'b0100 : 4'b0000);
      end
      if (exp) begin
        sb.push_back('{2, init_val(14'h0400 + 14'(beats)), cyc + 2});
        beats++;
      end
      n++;
    end
    req[2] = 1'b0;
    wait_drain();
    checks++;
    if (sb.size() != 0 || beats != 40) begin
      failures++;
      $display("FAIL burst_cap_drain got pending=%0d beats=%0d want 0 40",
               sb.size(), beats);
      sb.delete();
    end
  endtask

  task automatic test_rw_handover();
    we[0] = 1'b1;
    set_addr(0, 14'h0100);
    set_wdata(0, 16'hBEEF);
    req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL handover_gnt0 got %b want 0001", gnt);
    end
    we[3] = 1'b0;
    set_addr(3, 14'h0100);
    req[3] = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 14'h0100 ||
        mem_wdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL handover_write got en=%b we=%b addr=%h wd=%h want 1 1 0100 beef",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL handover_gnt3 got %b want 1000", gnt);
    end
    sb.push_back('{3, 16'hBEEF, cyc + 2});
    @(negedge clk);
    req[3] = 1'b0;
    wait_drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL handover_drain got pending=%0d want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_enable_gating();
    we[1] = 1'b1;
    set_addr(1, 14'h3000);
    set_wdata(1, 16'h1111);
    req[1] = 1'b1;
    @(negedge clk);
    we[2] = 1'b1;
    set_addr(2, 14'h3001);
    set_wdata(2, 16'h2222);
    req[2] = 1'b1;
    arb_enable = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (gnt !== 4'b0010) begin
        failures++;
        $display("FAIL gating_burst beat %0d got gnt=%b want 0010", b, gnt);
      end
      @(negedge clk);
    end
    req[1] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("FAIL gating_hold cycle %0d got gnt=%b busy=%b want 0000 0",
                 n, gnt, busy);
      end
    end
    arb_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL gating_resume got gnt=%b want 0100", gnt);
    end
    req[2] = 1'b0;
    we = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    we[1] = 1'b0;
    set_addr(1, 14'h0200);
    req[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL areset_gnt got %b want 0010", gnt);
    end
    sb.push_back('{1, init_val(14'h0200), cyc + 2});
    @(negedge clk);
    req[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
      failures++;
      $display("FAIL areset_outputs got gnt=%b rvalid=%b rdata=%h en=%b we=%b addr=%h wd=%h busy=%b want all 0",
               gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL areset_quiet got busy=%b gnt=%b want 0 0000", busy, gnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    arb_enable = 1'b0;
    req = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    test_reset();
    test_single_read();
    test_fairness();
    test_burst_cap();
    test_rw_handover();
    test_enable_gating();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
